// File: rtl/zh01_plasticity_engine.sv
// Multi-channel three-factor plasticity engine: per-channel eligibility traces that decay each
// time step, and a reward-triggered scan that streams saturated weight deltas over valid/ready.
`timescale 1ns/1ps

module zh01_plasticity_engine #(
    parameter int N_CH            = 8,
    parameter int TW              = 8,
    parameter int RW              = 8,
    parameter int WW              = 16,
    parameter int ETA_SHIFT       = 4,
    parameter int DECAY_SHIFT     = 3,
    parameter int TRACE_INC       = 32,
    parameter int CLEAR_ON_REWARD = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH-1:0]           pre_spk,
    input  logic [N_CH-1:0]           post_spk,
    input  logic                      rew_valid,
    output logic                      rew_ready,
    input  logic signed [RW-1:0]      reward,
    output logic                      dw_valid,
    input  logic                      dw_ready,
    output logic [$clog2(N_CH)-1:0]   dw_ch,
    output logic signed [WW-1:0]      dw_data,
    output logic                      busy
);

    localparam int KW = $clog2(N_CH);
    localparam int PW = TW + RW + 1;
    localparam logic [TW:0] INC = (TW + 1)'(TRACE_INC);
    localparam longint DW_MAX = (longint'(1) <<< (WW - 1)) - 1;
    localparam longint DW_MIN = -(longint'(1) <<< (WW - 1));

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic signed [RW-1:0]  r_q;
    logic [TW-1:0]         trace      [N_CH];
    logic [TW-1:0]         trace_step [N_CH];
    logic [TW-1:0]         decay_shr  [N_CH];
    logic [TW-1:0]         decay_amt  [N_CH];
    logic [TW:0]           sum_w      [N_CH];

    logic                  step_fire;
    logic                  rew_fire;
    logic                  k_last;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  q;
    longint                q_wide;
    logic signed [WW-1:0]  q_sat;
    logic                  q_nz;

    // A reward pending in IDLE blocks the step so the scan sees the pre-step traces.
    assign in_ready  = (state == IDLE) && !rew_valid;
    assign rew_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign step_fire = in_valid && in_ready;
    assign rew_fire  = rew_valid && rew_ready;
    assign k_last    = (k == KW'(N_CH - 1));

    // NOTE: every variable written here gets a value on every path, so no latches are inferred.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            decay_shr[i]  = trace[i] >> DECAY_SHIFT;
            decay_amt[i]  = (decay_shr[i] == '0) ? TW'(trace[i] != '0) : decay_shr[i];
            sum_w[i]      = {1'b0, trace[i] - decay_amt[i]}
                          + (((pre_spk[i] & post_spk[i]) != 1'b0) ? INC : '0);
            trace_step[i] = sum_w[i][TW] ? '1 : sum_w[i][TW-1:0];
        end
    end

    // Trace is unsigned, so it is widened with a zero sign bit before the signed multiply.
    always_comb begin
        prod   = PW'($signed({1'b0, trace[k]})) * PW'(r_q);
        q      = prod >>> ETA_SHIFT;
        q_wide = longint'(q);
        if (q_wide > DW_MAX)      q_sat = WW'(DW_MAX);
        else if (q_wide < DW_MIN) q_sat = WW'(DW_MIN);
        else                      q_sat = WW'(q);
        q_nz   = (q != '0);
    end

    // NOTE: the traces are a register file, not RAM, so they take the async reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) trace[i] <= '0;
        end else if (state == DONE && CLEAR_ON_REWARD != 0) begin
            for (int i = 0; i < N_CH; i++) trace[i] <= '0;
        end else if (step_fire) begin
            for (int i = 0; i < N_CH; i++) trace[i] <= trace_step[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            r_q      <= '0;
            dw_valid <= 1'b0;
            dw_ch    <= '0;
            dw_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rew_fire) begin
                        r_q   <= reward;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (q_nz) begin
                        dw_data  <= q_sat;
                        dw_ch    <= k;
                        dw_valid <= 1'b1;
                        state    <= EMIT;
                    end else if (k_last) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EMIT: begin
                    if (dw_ready) begin
                        dw_valid <= 1'b0;
                        if (k_last) begin
                            state <= DONE;
                        end else begin
                            k     <= k + 1'b1;
                            state <= CALC;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zh01_plasticity_engine.sv
// Scoreboard bench for zh01_plasticity_engine: two instances (WW=16 and WW=8) share stimulus,
// an arithmetic trace/reward model predicts deltas, and a monitor compares each presented delta.
`timescale 1ns/1ps

module tb_zh01_plasticity_engine;

    localparam int N_CH = 8;
    localparam int ETA  = 4;
    localparam int DS   = 3;
    localparam int INC  = 32;
    localparam int TMAX = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              rew_valid = 1'b0;
    logic              dw_ready = 1'b0;
    logic [7:0]        pre = '0;
    logic [7:0]        post = '0;
    logic signed [7:0] reward = '0;

    logic              in_ready_a, rew_ready_a, dw_valid_a, busy_a;
    logic [2:0]        dw_ch_a;
    logic signed [15:0] dw_data_a;
    logic              in_ready_b, rew_ready_b, dw_valid_b, busy_b;
    logic [2:0]        dw_ch_b;
    logic signed [7:0] dw_data_b;

    zh01_plasticity_engine #(.WW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .pre_spk(pre), .post_spk(post), .rew_valid(rew_valid), .rew_ready(rew_ready_a),
        .reward(reward), .dw_valid(dw_valid_a), .dw_ready(dw_ready), .dw_ch(dw_ch_a),
        .dw_data(dw_data_a), .busy(busy_a));

    zh01_plasticity_engine #(.WW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .pre_spk(pre), .post_spk(post), .rew_valid(rew_valid), .rew_ready(rew_ready_b),
        .reward(reward), .dw_valid(dw_valid_b), .dw_ready(dw_ready), .dw_ch(dw_ch_b),
        .dw_data(dw_data_b), .busy(busy_b));

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int d16;
        int d8;
    } exp_t;

    exp_t sb[$];
    int   tr[N_CH];
    int   checks = 0;
    int   fails = 0;
    int   hs_count = 0;
    int   ready_mode = 0;
    int   wait_cnt = 0;
    int   lat;
    int   busy_cyc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: plain integer rules for decay, increment and floor-divided reward product.
    task automatic model_step(input logic [7:0] p, input logic [7:0] s);
        int e;
        int d;
        for (int i = 0; i < N_CH; i++) begin
            e = tr[i];
            d = (e > 0) ? (((e >> DS) > 1) ? (e >> DS) : 1) : 0;
            e = e - d + ((p[i] && s[i]) ? INC : 0);
            tr[i] = (e > TMAX) ? TMAX : e;
        end
    endtask

    task automatic model_reward(input int r);
        int p;
        int f;
        exp_t x;
        for (int i = 0; i < N_CH; i++) begin
            p = tr[i] * r;
            f = (p >= 0) ? p / (1 << ETA) : -((-p + (1 << ETA) - 1) / (1 << ETA));
            if (f != 0) begin
                x.ch = i; x.d16 = sat(f, 16); x.d8 = sat(f, 8);
                sb.push_back(x);
            end
        end
        for (int i = 0; i < N_CH; i++) tr[i] = 0;
    endtask

    task automatic do_step(input logic [7:0] p, input logic [7:0] s);
        bit ok;
        ok = 1'b0;
        pre = p; post = s; in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (ok) model_step(p, s);
        else check("step_accept_timeout", 0, 1);
    endtask

    task automatic accept_reward(input int r);
        bit ok;
        ok = 1'b0;
        reward = 8'(r); rew_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = rew_ready_a;
            @(posedge clk);
            #1;
        end
        rew_valid = 1'b0;
        if (ok) model_reward(r);
        else check("reward_accept_timeout", 0, 1);
    endtask

    // Counts busy cycles and the negedge index at which dw_valid first shows.
    task automatic wait_scan();
        bit done;
        done = 1'b0;
        lat = -1;
        busy_cyc = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (dw_valid_a && lat < 0) lat = n + 1;
            if (!busy_a) done = 1'b1;
            else busy_cyc++;
        end
        if (!done) check("scan_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // dw_ready driver: 0 = always high, 1 = random, 2 = five low cycles per delta, 3 = always low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dw_ready = 1'b1;
                1: dw_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (dw_valid_a) begin
                        if (wait_cnt == 5) begin dw_ready = 1'b1; wait_cnt = 0; end
                        else begin dw_ready = 1'b0; wait_cnt++; end
                    end else begin
                        dw_ready = 1'b0; wait_cnt = 0;
                    end
                end
                default: dw_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every cycle a delta is presented it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy_a) check("in_ready_while_busy", int'(in_ready_a), 0);
                if (dw_valid_a) begin
                    if (sb.size() == 0) begin
                        check("dw_unexpected_ch", int'(dw_ch_a), -1);
                    end else begin
                        check("dw_ch", int'(dw_ch_a), sb[0].ch);
                        check("dw_data_ww16", int'(dw_data_a), sb[0].d16);
                        check("dw_valid_ww8", int'(dw_valid_b), 1);
                        check("dw_ch_ww8", int'(dw_ch_b), sb[0].ch);
                        check("dw_data_ww8", int'(dw_data_b), sb[0].d8);
                        if (dw_ready) begin
                            void'(sb.pop_front());
                            hs_count++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bit ok;
        for (int i = 0; i < N_CH; i++) tr[i] = 0;

        #23;
        check("rst_dw_valid", int'(dw_valid_a), 0);
        check("rst_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dw_ch", int'(dw_ch_a), 0);
        check("rst_dw_data", int'(dw_data_a), 0);
        check("rst_in_ready", int'(in_ready_a), 1);
        check("rst_rew_ready", int'(rew_ready_a), 1);
        @(posedge clk);
        #1;

        // Single coincidence on ch2, reward +64 -> ch2 gets +128, then traces are clear.
        do_step(8'h04, 8'h04);
        hs0 = hs_count;
        accept_reward(64);
        wait_scan();
        check("ch2_first_valid_latency", lat, 4);
        check("ch2_handshakes", hs_count - hs0, 1);
        accept_reward(64);
        wait_scan();
        check("cleared_no_output", lat, -1);
        check("empty_scan_cycles", busy_cyc, N_CH + 1);

        // One idle step decays 32 to 28; reward -3 floors -84/16 to -6.
        do_step(8'h01, 8'h01);
        do_step(8'h00, 8'h00);
        check("trace_after_decay", int'(dut_a.trace[0]), 28);
        accept_reward(-3);
        wait_scan();
        check("ch0_first_valid_latency", lat, 2);

        // Drive ch5 into trace saturation, then a -128 reward clamps in the narrow instance.
        for (int j = 0; j < 60; j++) do_step(8'h20, 8'h20);
        check("trace_saturated", int'(dut_a.trace[5]), TMAX);
        do_step(8'h20, 8'h20);
        check("trace_holds_at_max", int'(dut_a.trace[5]), TMAX);
        check("model_trace_max", tr[5], TMAX);
        accept_reward(-128);
        wait_scan();

        // Backpressure on channels 1, 3, 7.
        do_step(8'h8A, 8'h8A);
        ready_mode = 2;
        hs0 = hs_count;
        accept_reward(50);
        wait_scan();
        check("backpressure_handshakes", hs_count - hs0, 3);
        ready_mode = 0;

        // Same-cycle step and reward: reward wins, step lands after the scan.
        do_step(8'h01, 8'h01);
        pre = 8'h02; post = 8'h02; reward = 8'sd10;
        in_valid = 1'b1; rew_valid = 1'b1;
        @(negedge clk);
        check("collide_in_ready", int'(in_ready_a), 0);
        check("collide_rew_ready", int'(rew_ready_a), 1);
        @(posedge clk);
        #1;
        rew_valid = 1'b0;
        model_reward(10);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stalled_step_accepted", int'(ok), 1);
        model_step(8'h02, 8'h02);
        check("stalled_step_ch1", int'(dut_a.trace[1]), 32);
        check("stalled_step_ch0", int'(dut_a.trace[0]), 0);
        for (int j = 0; j < 100 && tr[1] != 5; j++) begin
            do_step(8'h00, 8'h00);
            check("decay_track", int'(dut_a.trace[1]), tr[1]);
        end
        check("decay_reached_5", tr[1], 5);
        for (int j = 1; j <= 5; j++) begin
            do_step(8'h00, 8'h00);
            check("decay_small_seq", int'(dut_a.trace[1]), 5 - j);
        end

        // Reset while a delta is held by dw_ready=0.
        do_step(8'h40, 8'h40);
        ready_mode = 3;
        accept_reward(100);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = dw_valid_a;
        end
        check("emit_reached", int'(ok), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < N_CH; i++) tr[i] = 0;
        #1;
        check("midscan_rst_dw_valid", int'(dw_valid_a), 0);
        check("midscan_rst_busy", int'(busy_a), 0);
        for (int i = 0; i < N_CH; i++) check("midscan_rst_trace", int'(dut_a.trace[i]), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        accept_reward(100);
        wait_scan();
        check("post_reset_no_output", lat, -1);
        check("post_reset_scan_cycles", busy_cyc, N_CH + 1);

        // Randomised steps and rewards with random backpressure.
        ready_mode = 1;
        for (int n = 0; n < 150; n++) begin
            logic [7:0] p;
            logic [7:0] s;
            int ch;
            if ($urandom_range(0, 3) == 0) begin
                accept_reward(int'($urandom_range(0, 255)) - 128);
                wait_scan();
            end else begin
                p = 8'($urandom);
                s = ($urandom_range(0, 1) == 1) ? p : 8'($urandom);
                do_step(p, s);
                ch = int'($urandom_range(0, N_CH - 1));
                check("rand_trace", int'(dut_a.trace[ch]), tr[ch]);
            end
        end
        ready_mode = 0;
        accept_reward(127);
        wait_scan();

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
